// File: rtl/integrity_path_buffer_pkg.sv
// Shared path ORAM constants, buffer geometry helpers and the buffer FSM encoding.
// Depth/AWidth are derived here so every consumer agrees on the path layout.
package integrity_path_buffer_pkg;

    localparam int unsigned PATH_BKTS  = 20;
    localparam int unsigned BOI_SLOTS  = 2;
    localparam int unsigned BKT_BURSTS = 5;
    localparam int unsigned NUM_BKTS   = PATH_BKTS + BOI_SLOTS;
    localparam int unsigned BURST_BITS = 512;
    localparam int unsigned IV_LATENCY = 2;

    localparam int unsigned DEPTH  = NUM_BKTS * BKT_BURSTS;
    localparam int unsigned AWIDTH = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FILL   = 2'd1;
    localparam logic [1:0] ST_VERIFY = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;

    function automatic int unsigned path_depth(input int unsigned nb, input int unsigned bb);
        return nb * bb;
    endfunction

    function automatic int unsigned path_awidth(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic int unsigned path_cwidth(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/integrity_path_buffer_prefetch_fifo.sv
// Four-entry prefetch FIFO between the drain read pipeline and the Out port.
// The head is read straight from registered storage so OutData stays stable under backpressure.
module path_buf_prefetch_fifo #(
    parameter int unsigned Width = 512
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             empty_o,
    output logic [2:0]       count_o
);

    logic [Width-1:0] mem_q [4];
    logic [1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             push_ok_s, pop_ok_s;

    // pointer and occupancy next-state
    always_comb begin
        push_ok_s = push_i && (cnt_q != 3'd4);
        pop_ok_s  = pop_i && (cnt_q != 3'd0);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + 2'd1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // storage and pointer registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            cnt_q    <= 3'd0;
            for (int k = 0; k < 4; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign empty_o = (cnt_q == 3'd0);
    assign count_o = cnt_q;

endmodule

// File: rtl/integrity_path_buffer.sv
// Buffers one ORAM path: fill from DDR, expose a RAM port to the integrity verifier,
// then drain the (possibly updated) path back out in address order.
module integrity_path_buffer
    import integrity_path_buffer_pkg::*;
#(
    parameter int unsigned DWidth    = BURST_BITS,
    parameter int unsigned BktBursts = BKT_BURSTS,
    parameter int unsigned NumBkts   = NUM_BKTS,
    parameter int unsigned Latency   = IV_LATENCY
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DWidth-1:0] InData,
    input  logic              InValid,
    output logic              InReady,
    output logic [DWidth-1:0] OutData,
    output logic              OutValid,
    input  logic              OutReady,
    output logic              PathReady,
    input  logic              PathDone,
    input  logic              IVRequest,
    input  logic              IVWrite,
    input  logic [path_awidth(path_depth(NumBkts, BktBursts))-1:0] IVAddress,
    input  logic [DWidth-1:0] IVDataIn,
    output logic [DWidth-1:0] IVDataOut,
    output logic              Error
);

    localparam int unsigned Depth  = path_depth(NumBkts, BktBursts);
    localparam int unsigned AWidth = path_awidth(Depth);
    localparam int unsigned AW1    = AWidth + 1;
    localparam int unsigned CWidth = path_cwidth(Depth);
    localparam logic [CWidth-1:0] LastC  = CWidth'(Depth - 1);
    localparam logic [CWidth-1:0] DepthC = CWidth'(Depth);
    localparam logic [AWidth:0]   DepthA = AW1'(Depth);

    logic [DWidth-1:0] ram [Depth];

    logic [1:0]        state_q, state_d;
    logic [CWidth-1:0] ptr_q, ptr_d, out_cnt_q, out_cnt_d;
    logic              path_ready_q, path_ready_d;
    logic              error_q, error_d;
    logic              done_pend_q, done_pend_d;
    logic [Latency-1:0] vld_q, drn_q;
    logic [DWidth-1:0] dat_q [Latency];

    logic              ram_we_s, rd_en_s, rd_drain_s, rd_ok_s;
    logic [AWidth-1:0] ram_waddr_s, rd_addr_s;
    logic [DWidth-1:0] ram_wdata_s, fifo_data_s;
    logic              iv_addr_ok_s, done_seen_s, out_fire_s, fifo_empty_s;
    logic [2:0]        fifo_cnt_s;
    logic [7:0]        occ_s;

    // protocol checks, sticky error and drain budget (FIFO entries plus drain reads in flight)
    always_comb begin
        iv_addr_ok_s = ({1'b0, IVAddress} < DepthA);
        done_seen_s  = done_pend_q || (PathDone && !path_ready_q);
        out_fire_s   = !fifo_empty_s && OutReady;
        if ((IVRequest && ((state_q != ST_VERIFY) || !iv_addr_ok_s)) ||
            (PathDone && (state_q == ST_FILL))) begin
            error_d = 1'b1;
        end else begin
            error_d = error_q;
        end
        occ_s = {5'd0, fifo_cnt_s};
        for (int k = 0; k < Latency; k++) begin
            occ_s = occ_s + {7'd0, drn_q[k]};
        end
    end

    // FSM next-state and RAM port muxing
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        out_cnt_d    = out_cnt_q;
        path_ready_d = 1'b0;
        done_pend_d  = done_pend_q;
        ram_we_s     = 1'b0;
        ram_waddr_s  = '0;
        ram_wdata_s  = InData;
        rd_en_s      = 1'b0;
        rd_drain_s   = 1'b0;
        rd_ok_s      = 1'b1;
        rd_addr_s    = '0;
        case (state_q)
            ST_IDLE: begin
                state_d     = ST_FILL;
                ptr_d       = '0;
                out_cnt_d   = '0;
                done_pend_d = 1'b0;
            end
            ST_FILL: begin
                if (InValid) begin
                    ram_we_s    = 1'b1;
                    ram_waddr_s = ptr_q[AWidth-1:0];
                    ptr_d       = ptr_q + CWidth'(1);
                    if (ptr_q == LastC) begin
                        state_d      = ST_VERIFY;
                        path_ready_d = 1'b1;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else begin
                    ram_we_s = 1'b0;
                end
            end
            ST_VERIFY: begin
                if (IVRequest && IVWrite) begin
                    ram_we_s    = iv_addr_ok_s;
                    ram_waddr_s = IVAddress;
                    ram_wdata_s = IVDataIn;
                end else if (IVRequest) begin
                    rd_en_s   = 1'b1;
                    rd_ok_s   = iv_addr_ok_s;
                    rd_addr_s = iv_addr_ok_s ? IVAddress : '0;
                end else begin
                    rd_en_s = 1'b0;
                end
                // hold off the drain until every verifier read has left the pipeline
                if (done_seen_s && !rd_en_s && (vld_q == '0)) begin
                    state_d     = ST_DRAIN;
                    ptr_d       = '0;
                    out_cnt_d   = '0;
                    done_pend_d = 1'b0;
                end else begin
                    done_pend_d = done_seen_s;
                end
            end
            ST_DRAIN: begin
                if ((ptr_q != DepthC) && (occ_s < 8'd4)) begin
                    rd_en_s    = 1'b1;
                    rd_drain_s = 1'b1;
                    rd_addr_s  = ptr_q[AWidth-1:0];
                    ptr_d      = ptr_q + CWidth'(1);
                end else begin
                    rd_en_s = 1'b0;
                end
                if (out_fire_s) begin
                    out_cnt_d = out_cnt_q + CWidth'(1);
                    if (out_cnt_q == LastC) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    out_cnt_d = out_cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // control state, read pipeline and output registers
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            out_cnt_q    <= '0;
            path_ready_q <= 1'b0;
            error_q      <= 1'b0;
            done_pend_q  <= 1'b0;
            vld_q        <= '0;
            drn_q        <= '0;
            for (int k = 0; k < Latency; k++) begin
                dat_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            out_cnt_q    <= out_cnt_d;
            path_ready_q <= path_ready_d;
            error_q      <= error_d;
            done_pend_q  <= done_pend_d;
            vld_q[0]     <= rd_en_s;
            drn_q[0]     <= rd_drain_s;
            if (rd_en_s) begin
                dat_q[0] <= rd_ok_s ? ram[rd_addr_s] : '0;
            end
            for (int k = 1; k < Latency; k++) begin
                vld_q[k] <= vld_q[k-1];
                drn_q[k] <= drn_q[k-1];
                dat_q[k] <= dat_q[k-1];
            end
        end
    end

    // path RAM write port; contents deliberately survive reset
    always_ff @(posedge Clock) begin
        if (ram_we_s) begin
            ram[ram_waddr_s] <= ram_wdata_s;
        end
    end

    path_buf_prefetch_fifo #(
        .Width (DWidth)
    ) u_prefetch_fifo (
        .clk_i   (Clock),
        .rst_ni  (Reset),
        .push_i  (vld_q[Latency-1] && drn_q[Latency-1]),
        .data_i  (dat_q[Latency-1]),
        .pop_i   (out_fire_s),
        .data_o  (fifo_data_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_cnt_s)
    );

    assign InReady   = (state_q == ST_FILL);
    assign OutValid  = !fifo_empty_s;
    assign OutData   = fifo_data_s;
    assign PathReady = path_ready_q;
    assign Error     = error_q;
    assign IVDataOut = dat_q[Latency-1];

endmodule

// File: tb/tb_integrity_path_buffer.sv
// Directed-plus-random bench for integrity_path_buffer: a plain array models the path RAM,
// a two-deep queue models verifier read latency, and drained beats are compared in address order.
module tb_integrity_path_buffer;

    logic         Clock, Reset;
    logic [511:0] InData, OutData, IVDataIn, IVDataOut;
    logic         InValid, InReady, OutValid, OutReady, PathReady, PathDone;
    logic         IVRequest, IVWrite, Error;
    logic [6:0]   IVAddress;

    int           errors = 0;
    int           checks = 0;
    logic [511:0] mem_m [110];
    bit           err_m;
    bit           p0_v, p1_v;
    logic [511:0] p0_d, p1_d;

    integrity_path_buffer dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .InData    (InData),
        .InValid   (InValid),
        .InReady   (InReady),
        .OutData   (OutData),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .PathReady (PathReady),
        .PathDone  (PathDone),
        .IVRequest (IVRequest),
        .IVWrite   (IVWrite),
        .IVAddress (IVAddress),
        .IVDataIn  (IVDataIn),
        .IVDataOut (IVDataOut),
        .Error     (Error)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // One fill of 110 beats with random InValid gaps; optional illegal IV write / PathDone injection.
    task automatic do_fill(input bit rnd, input int iv_at, input int pd_at);
        int beat, guard;
        bit inj_iv, inj_pd;
        beat = 0; guard = 0; inj_iv = 0; inj_pd = 0;
        while (!InReady && guard < 8) begin step(); guard++; end
        chk_b("fill_inready", InReady, 1'b1);
        while (beat < 110 && guard < 2000) begin
            InValid = ($urandom_range(0, 3) != 0);
            InData  = rnd ? rand512() : 512'(beat);
            if (!inj_iv && beat == iv_at) begin
                IVRequest = 1'b1; IVWrite = 1'b1; IVAddress = 7'd3; IVDataIn = rand512();
                inj_iv = 1; err_m = 1;
            end
            if (!inj_pd && beat == pd_at) begin
                PathDone = 1'b1; inj_pd = 1; err_m = 1;
            end
            step();
            IVRequest = 1'b0; PathDone = 1'b0; guard++;
            if (InValid) begin mem_m[beat] = InData; beat++; end
            chk_b("path_ready_pulse", PathReady, InValid && beat == 110);
        end
        InValid = 1'b0;
        chk_b("fill_done_inready", InReady, 1'b0);
        chk_b("fill_error", Error, err_m);
        step();
        chk_b("path_ready_single", PathReady, 1'b0);
    endtask

    // One verifier cycle; read data is expected two edges after the request.
    task automatic iv_op(input bit req, input bit wr, input logic [6:0] a, input logic [511:0] d);
        bit cur_v;
        logic [511:0] cur_d;
        IVRequest = req; IVWrite = wr; IVAddress = a; IVDataIn = d;
        cur_v = req && !wr;
        cur_d = '0;
        if (int'(a) < 110) cur_d = mem_m[a];
        if (req && wr && int'(a) < 110) mem_m[a] = d;
        if (req && int'(a) >= 110) err_m = 1;
        step();
        IVRequest = 1'b0; IVWrite = 1'b0;
        p1_v = p0_v; p1_d = p0_d; p0_v = cur_v; p0_d = cur_d;
        if (p1_v) chk_w("iv_rdata", IVDataOut, p1_d);
        chk_b("iv_error", Error, err_m);
    endtask

    // Drain with toggling or random OutReady until all beats (or stop_at beats) are taken.
    task automatic do_drain(input bit toggle, input int stop_at);
        int beat, cyc;
        bit held_v;
        logic [511:0] held_d;
        beat = 0; cyc = 0; held_v = 0; held_d = '0;
        while (beat < 110 && beat != stop_at && cyc < 3000) begin
            OutReady = toggle ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            if (held_v) begin
                chk_b("out_hold_valid", OutValid, 1'b1);
                chk_w("out_hold_data", OutData, held_d);
            end
            held_v = OutValid && !OutReady;
            held_d = OutData;
            if (OutValid && OutReady) begin
                chk_w("out_data", OutData, mem_m[beat]);
                beat++;
            end
            step();
            cyc++;
        end
        OutReady = 1'b0;
        chk_b("drain_beats", beat == ((stop_at < 0) ? 110 : stop_at), 1'b1);
    endtask

    initial begin
        InData = '0; InValid = 0; OutReady = 0; PathDone = 0;
        IVRequest = 0; IVWrite = 0; IVAddress = '0; IVDataIn = '0;
        err_m = 0; p0_v = 0; p1_v = 0; p0_d = '0; p1_d = '0;
        Reset = 1'b1;
        #1 Reset = 1'b0;
        #2;
        chk_b("rst_inready", InReady, 1'b0);
        chk_b("rst_outvalid", OutValid, 1'b0);
        chk_b("rst_pathready", PathReady, 1'b0);
        chk_b("rst_error", Error, 1'b0);
        #20 Reset = 1'b1;
        step();

        do_fill(1'b0, -1, -1);
        iv_op(1, 0, 7'd0, '0);
        iv_op(1, 0, 7'd1, '0);
        iv_op(1, 0, 7'd2, '0);
        iv_op(1, 1, 7'd5, 512'hABCD);
        iv_op(1, 0, 7'd5, '0);
        iv_op(0, 0, 7'd0, '0);
        iv_op(0, 0, 7'd0, '0);
        for (int i = 0; i < 40; i++) begin
            iv_op(1, ($urandom_range(0, 2) == 0), 7'($urandom_range(0, 109)), rand512());
        end
        iv_op(0, 0, 7'd0, '0);
        iv_op(0, 0, 7'd0, '0);
        PathDone = 1'b1; step(); PathDone = 1'b0;
        do_drain(1'b1, -1);
        chk_b("idle_after_drain", InReady, 1'b0);
        step();
        chk_b("refill_ready", InReady, 1'b1);

        do_fill(1'b1, 20, -1);
        iv_op(1, 1, 7'd110, rand512());
        iv_op(1, 0, 7'd110, '0);
        iv_op(1, 0, 7'd3, '0);
        iv_op(1, 0, 7'd127, '0);
        iv_op(0, 0, 7'd0, '0);
        iv_op(0, 0, 7'd0, '0);
        PathDone = 1'b1; step(); PathDone = 1'b0;
        do_drain(1'b0, 50);

        #1 Reset = 1'b0;
        #1;
        chk_b("midrst_inready", InReady, 1'b0);
        chk_b("midrst_outvalid", OutValid, 1'b0);
        chk_b("midrst_pathready", PathReady, 1'b0);
        chk_b("midrst_error", Error, 1'b0);
        chk_w("midrst_outdata", OutData, '0);
        chk_w("midrst_ivdata", IVDataOut, '0);
        err_m = 0; p0_v = 0; p1_v = 0;
        @(negedge Clock);
        Reset = 1'b1;
        step();
        do_fill(1'b0, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
